// File: rtl/rv32i_types.sv
// Shared types and constants for the RV32I front end.
package rv32i_types;

    // Fetch controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        FULL    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    // Address of the first instruction fetched after reset
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0060;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one word request at a time to instruction
// memory, presents fetched words to decode through an output slot backed by
// a one-entry skid buffer, and handles redirects, including redirects that
// arrive while a request is still in flight.
module fetch_stage
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;     // in-flight address while in DISCARD
    logic [31:0]  target_q, target_d;         // pending redirect target in DISCARD
    logic         slot_valid_q, slot_valid_d;
    logic [31:0]  slot_pc_q, slot_pc_d;
    logic [31:0]  slot_instr_q, slot_instr_d;
    logic         buf_valid_q, buf_valid_d;
    logic [31:0]  buf_pc_q, buf_pc_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic         consume;
    logic         resp_take;

    // Request is held on the fetch register until memory completes it
    assign imem_read    = (state_q == FETCH) || (state_q == DISCARD);
    assign imem_address = fetch_pc_q;
    assign if_valid     = slot_valid_q;
    assign if_pc        = slot_pc_q;
    assign if_instr     = slot_instr_q;

    // Next-state, slot/buffer steering and redirect handling
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        target_d     = target_q;
        slot_valid_d = slot_valid_q;
        slot_pc_d    = slot_pc_q;
        slot_instr_d = slot_instr_q;
        buf_valid_d  = buf_valid_q;
        buf_pc_d     = buf_pc_q;
        buf_instr_d  = buf_instr_q;

        consume   = slot_valid_q && !stall;
        resp_take = (state_q == FETCH) && imem_resp && !redirect;

        if (resp_take) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        // Buffer refills the slot ahead of a new response to keep order
        if (consume) begin
            if (buf_valid_q) begin
                slot_pc_d    = buf_pc_q;
                slot_instr_d = buf_instr_q;
                buf_valid_d  = 1'b0;
                if (resp_take) begin
                    buf_valid_d = 1'b1;
                    buf_pc_d    = fetch_pc_q;
                    buf_instr_d = imem_rdata;
                end
            end else if (resp_take) begin
                slot_pc_d    = fetch_pc_q;
                slot_instr_d = imem_rdata;
            end else begin
                slot_valid_d = 1'b0;
            end
        end else if (resp_take) begin
            if (!slot_valid_q) begin
                slot_valid_d = 1'b1;
                slot_pc_d    = fetch_pc_q;
                slot_instr_d = imem_rdata;
            end else begin
                buf_valid_d = 1'b1;
                buf_pc_d    = fetch_pc_q;
                buf_instr_d = imem_rdata;
            end
        end

        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (buf_valid_d) state_d = FULL;
            FULL:    if (!buf_valid_d) state_d = FETCH;
            DISCARD: begin
                // Stale response is dropped; resume at the saved target
                if (imem_resp) begin
                    state_d    = FETCH;
                    fetch_pc_d = target_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // A redirect flushes everything; an outstanding request must still
        // be waited out before the new target can be issued
        if (redirect) begin
            slot_valid_d = 1'b0;
            buf_valid_d  = 1'b0;
            if ((state_q == FETCH || state_q == DISCARD) && !imem_resp) begin
                state_d  = DISCARD;
                target_d = redirect_pc;
            end else begin
                state_d    = FETCH;
                fetch_pc_d = redirect_pc;
            end
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            target_q     <= RESET_PC;
            slot_valid_q <= 1'b0;
            slot_pc_q    <= 32'd0;
            slot_instr_q <= 32'd0;
            buf_valid_q  <= 1'b0;
            buf_pc_q     <= 32'd0;
            buf_instr_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            target_q     <= target_d;
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_instr_q <= slot_instr_d;
            buf_valid_q  <= buf_valid_d;
            buf_pc_q     <= buf_pc_d;
            buf_instr_q  <= buf_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic.
// The expected instruction stream (sequential PCs restarted by each redirect
// or reset) is queued by the stimulus side and consumed by a monitor.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h4000_0060;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_pc;
    int          tests    = 0;
    int          fails    = 0;
    int          consumed = 0;
    logic        hold_pending = 1'b0;
    logic [31:0] hold_addr    = 32'd0;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .stall        (stall),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'hDEAD_BEEF) + {a[7:0], a[31:8]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Keep the expected stream a few entries ahead of the monitor
    task automatic top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic restart_model(input logic [31:0] pc);
        exp_q.delete();
        model_pc = pc;
        top_up();
    endtask

    // Drive one cycle of inputs; memory only answers a live request
    task automatic drive(input bit st, input bit rd, input logic [31:0] rpc, input bit rsp);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_resp   = rsp && imem_read;
        imem_rdata  = mem_word(imem_address);
        if (rd) restart_model(rpc);
        top_up();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the expected stream on every accepted instruction and
    // checks that an unanswered request stays put
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pending) begin
                check("req_hold_read", {31'd0, imem_read}, 32'd1);
                check("req_hold_addr", imem_address, hold_addr);
            end
            if (if_valid && !stall && !redirect) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_empty: got pc %h, expected nothing", if_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_pc", if_pc, e.pc);
                    check("sb_instr", if_instr, e.instr);
                    consumed++;
                end
            end
            hold_pending = imem_read && !imem_resp;
            hold_addr    = imem_address;
        end else begin
            hold_pending = 1'b0;
        end
    end

    initial begin
        logic [31:0] rnd_pc;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_resp   = 1'b0;
        imem_rdata  = 32'd0;
        restart_model(RST_PC);
        repeat (3) @(posedge clk);
        #1;
        check("rst_read", {31'd0, imem_read}, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_instr", if_instr, 32'd0);

        // Reset release, back-to-back responses
        rst_n = 1'b1;
        next_cycle();
        check("start_read", {31'd0, imem_read}, 32'd1);
        check("start_addr0", imem_address, 32'h4000_0060);
        drive(0, 0, 0, 1); next_cycle();
        check("start_addr1", imem_address, 32'h4000_0064);
        check("start_valid", {31'd0, if_valid}, 32'd1);
        check("start_pc0", if_pc, 32'h4000_0060);
        check("start_instr0", if_instr, mem_word(32'h4000_0060));
        drive(0, 0, 0, 1); next_cycle();
        check("start_addr2", imem_address, 32'h4000_0068);
        check("start_pc1", if_pc, 32'h4000_0064);

        // Three stall cycles with 0x64 presented
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 1); next_cycle();
            check("stall_hold_pc", if_pc, 32'h4000_0064);
            check("stall_full_read", {31'd0, imem_read}, 32'd0);
        end
        drive(0, 0, 0, 1); next_cycle();
        check("resume_pc", if_pc, 32'h4000_0068);
        check("resume_addr", imem_address, 32'h4000_006C);
        drive(0, 0, 0, 1); next_cycle();
        check("resume_pc2", if_pc, 32'h4000_006C);

        // Redirect with a response pending for three cycles
        drive(0, 1, 32'h4000_0100, 0); next_cycle();
        check("disc_read", {31'd0, imem_read}, 32'd1);
        check("disc_addr", imem_address, 32'h4000_0070);
        check("disc_valid", {31'd0, if_valid}, 32'd0);
        drive(0, 0, 0, 0); next_cycle();
        check("disc_addr_hold", imem_address, 32'h4000_0070);
        drive(0, 0, 0, 1); next_cycle();
        check("disc_new_addr", imem_address, 32'h4000_0100);
        check("disc_valid2", {31'd0, if_valid}, 32'd0);
        drive(0, 0, 0, 0); next_cycle();
        check("disc_valid3", {31'd0, if_valid}, 32'd0);
        drive(0, 0, 0, 1); next_cycle();
        check("disc_first_pc", if_pc, 32'h4000_0100);
        check("disc_first_valid", {31'd0, if_valid}, 32'd1);

        // Redirect coincident with a response while stalled
        drive(1, 1, 32'h4000_0200, 1); next_cycle();
        check("coinc_valid", {31'd0, if_valid}, 32'd0);
        check("coinc_addr", imem_address, 32'h4000_0200);
        check("coinc_read", {31'd0, imem_read}, 32'd1);
        drive(0, 0, 0, 1); next_cycle();
        check("coinc_pc", if_pc, 32'h4000_0200);

        // Asynchronous reset in the middle of an outstanding request
        drive(0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_read", {31'd0, imem_read}, 32'd0);
        check("arst_valid", {31'd0, if_valid}, 32'd0);
        check("arst_pc", if_pc, 32'd0);
        check("arst_instr", if_instr, 32'd0);
        restart_model(RST_PC);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        check("arst_restart", imem_address, 32'h4000_0060);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rnd_pc = $urandom;
            rnd_pc[1:0] = 2'b00;
            drive(($urandom % 3) == 0, ($urandom % 20) == 0, rnd_pc, ($urandom % 4) != 0);
            next_cycle();
        end
        drive(0, 0, 0, 0);
        next_cycle();
        check("progress", {31'd0, consumed >= 300}, 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
